// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// tdm_pkg : shared state type and slot constants for the TDM 1-to-4 demux
// Revision: 1.0
// ============================================================================
package tdm_pkg;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        SYNC = 1'b1
    } tdm_state_t;

    localparam logic [1:0] SLOT_FIRST = 2'd0;
    localparam logic [1:0] SLOT_LAST  = 2'd3;
    localparam int         NUM_SLOTS  = 4;

endpackage
`default_nettype wire

// File: rtl/tdm_slot_counter.sv
`default_nettype none
// ============================================================================
// tdm_slot_counter : modulo-4 slot index with load-to-0/1 and first/last flags
// Revision: 1.0
// ============================================================================
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_inc,
    input  logic       i_load0,
    input  logic       i_load1,
    output logic [1:0] o_slot,
    output logic       o_is_first,
    output logic       o_is_last
);

    logic [1:0] r_slot;

    // Loads win over increment: a marker always restarts the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= SLOT_FIRST;
        end else if (i_load0) begin
            r_slot <= SLOT_FIRST;
        end else if (i_load1) begin
            r_slot <= SLOT_FIRST + 2'd1;
        end else if (i_inc) begin
            r_slot <= r_slot + 2'd1;
        end
    end

    assign o_slot     = r_slot;
    assign o_is_first = (r_slot == SLOT_FIRST);
    assign o_is_last  = (r_slot == SLOT_LAST);

endmodule
`default_nettype wire

// File: rtl/tdm_demux14.sv
`default_nettype none
// ============================================================================
// tdm_demux14 : frame-locked TDM 1-to-4 demultiplexer, publishes whole frames
// Revision: 1.0
// ============================================================================
module tdm_demux14
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] d0,
    output logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] d3,
    output logic             frame_valid,
    output logic             sync_err,
    output logic             locked,
    output logic [1:0]       slot
);

    tdm_state_t       r_state;
    tdm_state_t       w_next_state;
    logic [1:0]       w_slot;
    logic             w_is_first;
    logic             w_is_last;
    logic             w_inc;
    logic             w_load0;
    logic             w_load1;
    logic             w_wr;
    logic [1:0]       w_wr_slot;
    logic             w_publish;
    logic             w_err;
    logic [WIDTH-1:0] r_shadow [NUM_SLOTS-1];
    logic [WIDTH-1:0] r_d0;
    logic [WIDTH-1:0] r_d1;
    logic [WIDTH-1:0] r_d2;
    logic [WIDTH-1:0] r_d3;
    logic             r_frame_valid;
    logic             r_sync_err;

    tdm_slot_counter u_slot_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_inc      (w_inc),
        .i_load0    (w_load0),
        .i_load1    (w_load1),
        .o_slot     (w_slot),
        .o_is_first (w_is_first),
        .o_is_last  (w_is_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_inc        = 1'b0;
        w_load0      = 1'b0;
        w_load1      = 1'b0;
        w_wr         = 1'b0;
        w_wr_slot    = SLOT_FIRST;
        w_publish    = 1'b0;
        w_err        = 1'b0;
        if (din_valid) begin
            case (r_state)
                HUNT: begin
                    if (frame_sync) begin
                        w_wr         = 1'b1;
                        w_load1      = 1'b1;
                        w_next_state = SYNC;
                    end
                end
                SYNC: begin
                    if (frame_sync) begin
                        // A marker always starts a new frame; mid-frame it also flags the drop.
                        w_wr = 1'b1;
                        if (w_is_first) begin
                            w_inc = 1'b1;
                        end else begin
                            w_err   = 1'b1;
                            w_load1 = 1'b1;
                        end
                    end else if (w_is_first) begin
                        w_err        = 1'b1;
                        w_load0      = 1'b1;
                        w_next_state = HUNT;
                    end else begin
                        w_wr      = 1'b1;
                        w_wr_slot = w_slot;
                        w_inc     = 1'b1;
                        w_publish = w_is_last;
                    end
                end
                default: begin
                    w_next_state = HUNT;
                    w_load0      = 1'b1;
                end
            endcase
        end
    end

    // Slots 0..2 are buffered; the slot-3 sample goes straight into the output bank.
    generate
        for (genvar i = 0; i < NUM_SLOTS - 1; i++) begin : g_shadow
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_shadow[i] <= '0;
                end else if (w_wr && (w_wr_slot == 2'(i))) begin
                    r_shadow[i] <= din;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d0          <= '0;
            r_d1          <= '0;
            r_d2          <= '0;
            r_d3          <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_frame_valid <= w_publish;
            r_sync_err    <= w_err;
            if (w_publish) begin
                r_d0 <= r_shadow[0];
                r_d1 <= r_shadow[1];
                r_d2 <= r_shadow[2];
                r_d3 <= din;
            end
        end
    end

    assign d0          = r_d0;
    assign d1          = r_d1;
    assign d2          = r_d2;
    assign d3          = r_d3;
    assign frame_valid = r_frame_valid;
    assign sync_err    = r_sync_err;
    assign locked      = (r_state == SYNC);
    assign slot        = w_slot;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux14.sv
`default_nettype none
// ============================================================================
// tb_tdm_demux14 : directed scoreboard bench, WIDTH=8 and WIDTH=1 instances
// Revision: 1.0
// ============================================================================
module tb_tdm_demux14;

    logic       clk;
    logic       rst_n;
    logic [7:0] din8;
    logic       din_valid;
    logic       frame_sync;

    logic [7:0] a_d0, a_d1, a_d2, a_d3;
    logic       a_fv, a_err, a_lock;
    logic [1:0] a_slot;
    logic       b_d0, b_d1, b_d2, b_d3;
    logic       b_fv, b_err, b_lock;
    logic [1:0] b_slot;

    tdm_demux14 #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .din(din8), .din_valid(din_valid),
        .frame_sync(frame_sync), .d0(a_d0), .d1(a_d1), .d2(a_d2), .d3(a_d3),
        .frame_valid(a_fv), .sync_err(a_err), .locked(a_lock), .slot(a_slot)
    );

    tdm_demux14 #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din(din8[0]), .din_valid(din_valid),
        .frame_sync(frame_sync), .d0(b_d0), .d1(b_d1), .d2(b_d2), .d3(b_d3),
        .frame_valid(b_fv), .sync_err(b_err), .locked(b_lock), .slot(b_slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    logic        m_sync;
    logic [1:0]  m_slot;
    logic [7:0]  m_sh [4];
    logic [31:0] m_pub;
    logic [31:0] q_exp [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic chk_outputs(input string tag, input logic efv, input logic eerr);
        chk({tag, " fv8"},   32'(a_fv),   32'(efv));
        chk({tag, " fv1"},   32'(b_fv),   32'(efv));
        chk({tag, " err8"},  32'(a_err),  32'(eerr));
        chk({tag, " err1"},  32'(b_err),  32'(eerr));
        chk({tag, " lock8"}, 32'(a_lock), 32'(m_sync));
        chk({tag, " lock1"}, 32'(b_lock), 32'(m_sync));
        chk({tag, " slot8"}, 32'(a_slot), 32'(m_slot));
        chk({tag, " slot1"}, 32'(b_slot), 32'(m_slot));
        chk({tag, " lanes8"}, {a_d0, a_d1, a_d2, a_d3}, m_pub);
        chk({tag, " lanes1"}, 32'({b_d0, b_d1, b_d2, b_d3}),
            32'({m_pub[24], m_pub[16], m_pub[8], m_pub[0]}));
    endtask

    task automatic model_reset();
        m_sync = 1'b0;
        m_slot = 2'd0;
        m_pub  = '0;
        for (int i = 0; i < 4; i++) m_sh[i] = '0;
        q_exp.delete();
    endtask

    task automatic send(input string tag, input logic v, input logic fs, input logic [7:0] d);
        logic efv;
        logic eerr;
        efv  = 1'b0;
        eerr = 1'b0;
        @(negedge clk);
        din_valid  = v;
        frame_sync = fs;
        din8       = d;
        if (v) begin
            if (!m_sync) begin
                if (fs) begin
                    m_sh[0] = d;
                    m_slot  = 2'd1;
                    m_sync  = 1'b1;
                end
            end else if (fs) begin
                if (m_slot != 2'd0) eerr = 1'b1;
                m_sh[0] = d;
                m_slot  = 2'd1;
            end else if (m_slot == 2'd0) begin
                eerr   = 1'b1;
                m_sync = 1'b0;
            end else begin
                m_sh[m_slot] = d;
                if (m_slot == 2'd3) begin
                    efv = 1'b1;
                    q_exp.push_back({m_sh[0], m_sh[1], m_sh[2], m_sh[3]});
                end
                m_slot = m_slot + 2'd1;
            end
        end
        @(posedge clk);
        #1;
        if (a_fv === 1'b1) begin
            n_total++;
            assert (q_exp.size() > 0) n_pass++;
            else $error("FAIL %s pop: got frame_valid want empty scoreboard", tag);
            if (q_exp.size() > 0) m_pub = q_exp.pop_front();
        end
        chk_outputs(tag, efv, eerr);
        din_valid  = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic send_frame(input string tag, input logic [7:0] f0, input logic [7:0] f1,
                              input logic [7:0] f2, input logic [7:0] f3);
        send({tag, ".s0"}, 1'b1, 1'b1, f0);
        send({tag, ".s1"}, 1'b1, 1'b0, f1);
        send({tag, ".s2"}, 1'b1, 1'b0, f2);
        send({tag, ".s3"}, 1'b1, 1'b0, f3);
    endtask

    initial begin
        rst_n      = 1'b0;
        din8       = '0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_outputs("reset", 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Hunting: unmarked samples are discarded
        for (int i = 0; i < 3; i++) send("hunt", 1'b1, 1'b0, 8'h01);
        send_frame("lock", 8'h01, 8'h00, 8'h00, 8'h00);

        // Back-to-back frames
        send_frame("b2b1", 8'h00, 8'h01, 8'h00, 8'h00);
        send_frame("b2b2", 8'h00, 8'h00, 8'h01, 8'h00);
        send_frame("b2b3", 8'h00, 8'h00, 8'h00, 8'h01);

        // Gaps stretch the frame; a marker without din_valid is ignored
        send("gap.s0", 1'b1, 1'b1, 8'h01);
        send("gap.s1", 1'b1, 1'b0, 8'h01);
        send("gap.i0", 1'b0, 1'b1, 8'h00);
        send("gap.i1", 1'b0, 1'b0, 8'h01);
        send("gap.s2", 1'b1, 1'b0, 8'h00);
        send("gap.s3", 1'b1, 1'b0, 8'h01);

        // Early marker on slot 2: partial frame dropped, new frame publishes
        send("early.s0", 1'b1, 1'b1, 8'h00);
        send("early.s1", 1'b1, 1'b0, 8'h00);
        send("early.mk", 1'b1, 1'b1, 8'h01);
        send("early.n1", 1'b1, 1'b0, 8'h00);
        send("early.n2", 1'b1, 1'b0, 8'h01);
        send("early.n3", 1'b1, 1'b0, 8'h00);

        // Reset mid-frame, no clock edge between assertion and check
        send("mid.s0", 1'b1, 1'b1, 8'h01);
        send("mid.s1", 1'b1, 1'b0, 8'h01);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_outputs("midrst", 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Byte-wide frames and missing-marker recovery
        send_frame("w8a", 8'hA5, 8'h3C, 8'hFF, 8'h00);
        send("miss", 1'b1, 1'b0, 8'h77);
        send("hunt2", 1'b1, 1'b0, 8'h5A);
        send_frame("w8b", 8'h00, 8'hFF, 8'h3C, 8'hA5);
        send("miss2", 1'b1, 1'b0, 8'h11);
        send_frame("w8c", 8'hFF, 8'hA5, 8'h00, 8'h3C);
        send("idle", 1'b0, 1'b0, 8'h00);

        n_total++;
        assert (q_exp.size() == 0) n_pass++;
        else $error("FAIL sb_drain: got %0d pending want 0", q_exp.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
